// File: rtl/rgb_led_fader_pkg.sv
// Shared types and defaults for the RGB LED fader: channel state encoding,
// default sizing and the prescaler width helper.
package rgb_led_fader_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RISE = 2'd1,
      ON   = 2'd2,
      FALL = 2'd3
   } ch_state_t;

   localparam int DEF_PWM_BITS = 8;
   localparam int DEF_RAMP_DIV = 11718;

   // A divide-by-1 prescaler still needs a one-bit counter to stay legal.
   function automatic int ramp_cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/rgb_led_fader_if.sv
// Sequencer-to-fader bundle: per-colour requests and run enable in,
// PWM pin drives, brightness levels and busy flag out.
interface rgb_led_fader_if
   import rgb_led_fader_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
);

   logic                enable;
   logic                req_red;
   logic                req_green;
   logic                req_blue;
   logic                led_red;
   logic                led_green;
   logic                led_blue;
   logic [PWM_BITS-1:0] level_red;
   logic [PWM_BITS-1:0] level_green;
   logic [PWM_BITS-1:0] level_blue;
   logic                busy;

   modport master (
      output enable, req_red, req_green, req_blue,
      input  led_red, led_green, led_blue,
      input  level_red, level_green, level_blue, busy
   );

   modport slave (
      input  enable, req_red, req_green, req_blue,
      output led_red, led_green, led_blue,
      output level_red, level_green, level_blue, busy
   );

endinterface

// File: rtl/rgb_led_fader_channel.sv
// One colour channel: OFF/RISE/ON/FALL state machine with a saturating
// brightness level that moves one step per prescaler tick.
module fade_channel
   import rgb_led_fader_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                enable,
   input  logic                step_tick,
   input  logic                req,
   output logic [PWM_BITS-1:0] level,
   output logic                busy
);

   localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

   ch_state_t           state_reg, state_next;
   logic [PWM_BITS-1:0] level_reg, level_next;

   // A request edge always takes priority over a coincident step.
   always_comb begin
      state_next = state_reg;
      level_next = level_reg;
      if (enable) begin
         case (state_reg)
            OFF: begin
               level_next = '0;
               if (req) state_next = RISE;
            end
            RISE: begin
               if (!req) begin
                  state_next = FALL;
               end else if (step_tick) begin
                  if (level_reg >= MAX_LEVEL - 1'b1) begin
                     level_next = MAX_LEVEL;
                     state_next = ON;
                  end else begin
                     level_next = level_reg + 1'b1;
                  end
               end
            end
            ON: begin
               level_next = MAX_LEVEL;
               if (!req) state_next = FALL;
            end
            FALL: begin
               if (req) begin
                  state_next = RISE;
               end else if (step_tick) begin
                  if (level_reg <= 1) begin
                     level_next = '0;
                     state_next = OFF;
                  end else begin
                     level_next = level_reg - 1'b1;
                  end
               end
            end
            default: begin
               state_next = OFF;
               level_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= OFF;
         level_reg <= '0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
      end
   end

   assign level = level_reg;
   assign busy  = (state_reg == RISE) || (state_reg == FALL);

endmodule

// File: rtl/rgb_led_fader.sv
// RGB LED fader top: shared PWM counter and ramp prescaler, three fade
// channels, registered pin drivers and the aggregate busy flag.
module rgb_led_fader
   import rgb_led_fader_pkg::*;
#(
   parameter int PWM_BITS   = DEF_PWM_BITS,
   parameter int RAMP_DIV   = DEF_RAMP_DIV,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic           clock_12mhz,
   input  logic           reset,
   rgb_led_fader_if.slave bus
);

   localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
   localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX_LEVEL - 1'b1;
   localparam int                  DIV_W     = ramp_cnt_width(RAMP_DIV);
   localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);
   localparam logic [2:0]          LED_IDLE  = {3{ACTIVE_LOW}};

   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [DIV_W-1:0]    div_cnt_reg;
   logic                step_tick;
   logic [2:0]          req_vec;
   logic [2:0]          ch_busy;
   logic [2:0]          cmp_on;
   logic [2:0]          led_reg;
   logic [PWM_BITS-1:0] level_arr [3];

   assign step_tick = bus.enable && (div_cnt_reg == DIV_LAST);
   assign req_vec   = {bus.req_blue, bus.req_green, bus.req_red};

   // PWM period is MAX_LEVEL cycles so that MAX_LEVEL compares on every cycle.
   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         pwm_cnt_reg <= '0;
         div_cnt_reg <= '0;
      end else if (bus.enable) begin
         pwm_cnt_reg <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
         div_cnt_reg <= step_tick ? '0 : div_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         fade_channel #(
            .PWM_BITS (PWM_BITS)
         ) u_ch (
            .clk       (clock_12mhz),
            .srst      (reset),
            .enable    (bus.enable),
            .step_tick (step_tick),
            .req       (req_vec[gi]),
            .level     (level_arr[gi]),
            .busy      (ch_busy[gi])
         );

         assign cmp_on[gi] = level_arr[gi] > pwm_cnt_reg;
      end
   endgenerate

   always_ff @(posedge clock_12mhz) begin
      if (reset || !bus.enable) begin
         led_reg <= LED_IDLE;
      end else begin
         led_reg <= cmp_on ^ LED_IDLE;
      end
   end

   assign bus.led_red     = led_reg[0];
   assign bus.led_green   = led_reg[1];
   assign bus.led_blue    = led_reg[2];
   assign bus.level_red   = level_arr[0];
   assign bus.level_green = level_arr[1];
   assign bus.level_blue  = level_arr[2];
   assign bus.busy        = |ch_busy;

endmodule

// File: tb/tb_rgb_led_fader.sv
// Directed bench for rgb_led_fader with PWM_BITS=4, RAMP_DIV=4; expected
// values are hand-derived from cycle counts after each reset release.
`timescale 1ns/1ps
module tb_rgb_led_fader;

   logic clock_12mhz = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   high_cnt;

   always #5 clock_12mhz = ~clock_12mhz;

   rgb_led_fader_if #(.PWM_BITS(4)) bus ();

   rgb_led_fader #(
      .PWM_BITS   (4),
      .RAMP_DIV   (4),
      .ACTIVE_LOW (1'b0)
   ) dut (
      .clock_12mhz (clock_12mhz),
      .reset       (reset),
      .bus         (bus)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end else begin
         $display("ok   %s @cyc %0d: %0d", tag, cyc, got);
      end
   endtask

   // Advance to #1 after edge number target (edge 0 = reset release point).
   task automatic adv_to(input int target);
      while (cyc < target) begin
         @(posedge clock_12mhz);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.enable    = 1'b1;
      bus.req_red   = 1'b0;
      bus.req_green = 1'b0;
      bus.req_blue  = 1'b0;
      repeat (3) @(posedge clock_12mhz);
      #1;
      cyc = 0;
      check_val("rst_level_r", int'(bus.level_red), 0);
      check_val("rst_level_g", int'(bus.level_green), 0);
      check_val("rst_level_b", int'(bus.level_blue), 0);
      check_val("rst_led_r", int'(bus.led_red), 0);
      check_val("rst_led_g", int'(bus.led_green), 0);
      check_val("rst_led_b", int'(bus.led_blue), 0);
      check_val("rst_busy", int'(bus.busy), 0);
      reset = 1'b0;
   endtask

   initial begin
      // Full red rise: ticks land on edges 4,8,..,60.
      do_reset();
      bus.req_red = 1'b1;
      adv_to(1);
      check_val("rise_busy", int'(bus.busy), 1);
      check_val("rise_l0", int'(bus.level_red), 0);
      adv_to(4);
      check_val("rise_l1", int'(bus.level_red), 1);
      adv_to(59);
      check_val("rise_l14", int'(bus.level_red), 14);
      check_val("rise_busy14", int'(bus.busy), 1);
      adv_to(60);
      check_val("rise_l15", int'(bus.level_red), 15);
      check_val("on_busy", int'(bus.busy), 0);
      for (int m = 61; m <= 75; m++) begin
         adv_to(m);
         check_val("full_led_r", int'(bus.led_red), 1);
      end

      // Drop red at level 8, decay to 0 in 32 cycles.
      do_reset();
      bus.req_red = 1'b1;
      adv_to(32);
      check_val("drop_l8", int'(bus.level_red), 8);
      bus.req_red = 1'b0;
      adv_to(33);
      check_val("drop_hold8", int'(bus.level_red), 8);
      check_val("drop_busy", int'(bus.busy), 1);
      adv_to(36);
      check_val("fall_l7", int'(bus.level_red), 7);
      adv_to(63);
      check_val("fall_l1", int'(bus.level_red), 1);
      check_val("fall_busy1", int'(bus.busy), 1);
      adv_to(64);
      check_val("fall_l0", int'(bus.level_red), 0);
      check_val("off_busy", int'(bus.busy), 0);

      // Green parked at 5 by toggling its request on every tick cycle.
      do_reset();
      bus.req_green = 1'b1;
      adv_to(20);
      check_val("grn_l5", int'(bus.level_green), 5);
      high_cnt = 0;
      for (int m = 21; m <= 50; m++) begin
         adv_to(m);
         check_val("grn_hold5", int'(bus.level_green), 5);
         check_val("grn_pwm", int'(bus.led_green),
                   ((m % 15) >= 1 && (m % 15) <= 5) ? 1 : 0);
         if (m >= 31 && m <= 45 && bus.led_green) high_cnt++;
         if (m % 4 == 3) bus.req_green = ~bus.req_green;
      end
      check_val("grn_duty", high_cnt, 5);
      check_val("grn_busy", int'(bus.busy), 1);
      check_val("grn_red_idle", int'(bus.level_red), 0);

      // Blue 1->0->1 across a tick: no step on either transition edge.
      do_reset();
      bus.req_blue = 1'b1;
      adv_to(8);
      check_val("blu_l2", int'(bus.level_blue), 2);
      adv_to(11);
      bus.req_blue = 1'b0;
      adv_to(12);
      check_val("blu_fall_hold", int'(bus.level_blue), 2);
      check_val("blu_busy", int'(bus.busy), 1);
      bus.req_blue = 1'b1;
      adv_to(13);
      check_val("blu_rise_hold", int'(bus.level_blue), 2);
      adv_to(15);
      check_val("blu_pre_step", int'(bus.level_blue), 2);
      adv_to(16);
      check_val("blu_l3", int'(bus.level_blue), 3);

      // Freeze at level 6 for 20 cycles, resume, then reset mid-ramp.
      do_reset();
      bus.req_red   = 1'b1;
      bus.req_green = 1'b1;
      adv_to(24);
      check_val("frz_l6", int'(bus.level_red), 6);
      adv_to(25);
      bus.enable = 1'b0;
      for (int m = 26; m <= 45; m++) begin
         adv_to(m);
         check_val("frz_level", int'(bus.level_red), 6);
         check_val("frz_led_r", int'(bus.led_red), 0);
         check_val("frz_led_g", int'(bus.led_green), 0);
         if (m == 30) bus.req_red = 1'b0;
         if (m == 40) bus.req_red = 1'b1;
      end
      check_val("frz_busy", int'(bus.busy), 1);
      bus.enable = 1'b1;
      adv_to(47);
      check_val("resume_l6", int'(bus.level_red), 6);
      adv_to(48);
      check_val("resume_l7", int'(bus.level_red), 7);
      check_val("resume_g7", int'(bus.level_green), 7);
      adv_to(50);
      reset = 1'b1;
      adv_to(51);
      check_val("mid_rst_r", int'(bus.level_red), 0);
      check_val("mid_rst_g", int'(bus.level_green), 0);
      check_val("mid_rst_b", int'(bus.level_blue), 0);
      check_val("mid_rst_busy", int'(bus.busy), 0);
      check_val("mid_rst_led", int'(bus.led_red), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
